// File: rtl/alu_op_executor_if.sv
// Operand/result handshake bundle for the ALU op executor.
// master drives operands and result-ready; slave is the executor.
interface alu_op_executor_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       in_op;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic             out_zero;

  modport master (
    output in_valid,
    output in_op,
    output in_a,
    output in_b,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_result,
    input  out_zero
  );

  modport slave (
    input  in_valid,
    input  in_op,
    input  in_a,
    input  in_b,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_result,
    output out_zero
  );
endinterface

// File: rtl/alu_op_executor.sv
// Execute-stage ALU: single-cycle logic/arith/compare ops,
// iterative one-bit-per-cycle shifts, registered result.
module alu_op_executor #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input logic              clk,
  input logic              reset,
  input logic              flush,
  alu_op_executor_if.slave bus
);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SLL = 4'b0011;
  localparam logic [3:0] OP_SRL = 4'b0100;
  localparam logic [3:0] OP_SUB = 4'b0101;
  localparam logic [3:0] OP_SRA = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_BEQ = 4'b1000;
  localparam logic [3:0] OP_BNE = 4'b1001;
  localparam logic [3:0] OP_BLT = 4'b1010;
  localparam logic [3:0] OP_BGE = 4'b1011;
  localparam logic [3:0] OP_XOR = 4'b1100;
  localparam logic [3:0] OP_LUI = 4'b1101;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic [1:0] K_SLL = 2'd0;
  localparam logic [1:0] K_SRL = 2'd1;
  localparam logic [1:0] K_SRA = 2'd2;

  localparam logic [SHAMT_W-1:0] CNT_ONE = SHAMT_W'(1);

  logic [1:0]         state;
  logic [1:0]         kind;
  logic [WIDTH-1:0]   acc;
  logic [SHAMT_W-1:0] cnt;
  logic [WIDTH-1:0]   result;
  logic               zero;

  logic [SHAMT_W-1:0] shamt;
  logic               is_shift;
  logic [1:0]         kind_in;
  logic [WIDTH-1:0]   alu_res;
  logic [WIDTH-1:0]   acc_next;
  logic               lt;
  logic               eq;
  logic               accept;

  assign shamt  = bus.in_b[SHAMT_W-1:0];
  assign lt     = $signed(bus.in_a) < $signed(bus.in_b);
  assign eq     = bus.in_a == bus.in_b;
  assign accept = bus.in_valid && bus.in_ready && !flush;

  assign bus.in_ready   = (state == S_IDLE) && !reset;
  assign bus.out_valid  = (state == S_DONE);
  assign bus.out_result = result;
  assign bus.out_zero   = zero;

  // Single-cycle result; shifts land here only with shamt 0.
  always_comb begin
    alu_res  = '0;
    is_shift = 1'b0;
    kind_in  = K_SLL;
    case (bus.in_op)
      OP_AND: alu_res = bus.in_a & bus.in_b;
      OP_OR:  alu_res = bus.in_a | bus.in_b;
      OP_ADD: alu_res = bus.in_a + bus.in_b;
      OP_SUB: alu_res = bus.in_a - bus.in_b;
      OP_XOR: alu_res = bus.in_a ^ bus.in_b;
      OP_LUI: alu_res = bus.in_b;
      OP_SLT: alu_res = WIDTH'(lt);
      OP_BEQ: alu_res = WIDTH'(eq);
      OP_BNE: alu_res = WIDTH'(!eq);
      OP_BLT: alu_res = WIDTH'(lt);
      OP_BGE: alu_res = WIDTH'(!lt);
      OP_SLL: begin
        alu_res  = bus.in_a;
        is_shift = 1'b1;
        kind_in  = K_SLL;
      end
      OP_SRL: begin
        alu_res  = bus.in_a;
        is_shift = 1'b1;
        kind_in  = K_SRL;
      end
      OP_SRA: begin
        alu_res  = bus.in_a;
        is_shift = 1'b1;
        kind_in  = K_SRA;
      end
      default: alu_res = '0;
    endcase
  end

  // One-bit step of the latched shift direction.
  always_comb begin
    acc_next = acc;
    unique case (1'b1)
      kind == K_SLL: acc_next = {acc[WIDTH-2:0], 1'b0};
      kind == K_SRL: acc_next = {1'b0, acc[WIDTH-1:1]};
      default:       acc_next = {acc[WIDTH-1], acc[WIDTH-1:1]};
    endcase
  end

  // Control FSM plus operand/result registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      kind   <= K_SLL;
      acc    <= '0;
      cnt    <= '0;
      result <= '0;
      zero   <= 1'b0;
    end else if (flush) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            if (is_shift && shamt != '0) begin
              state <= S_SHIFT;
              acc   <= bus.in_a;
              cnt   <= shamt;
              kind  <= kind_in;
            end else begin
              state  <= S_DONE;
              result <= alu_res;
              zero   <= (alu_res == '0);
            end
          end
        end
        S_SHIFT: begin
          acc <= acc_next;
          cnt <= cnt - CNT_ONE;
          if (cnt == CNT_ONE) begin
            state  <= S_DONE;
            result <= acc_next;
            zero   <= (acc_next == '0);
          end
        end
        S_DONE: begin
          if (bus.out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_executor.sv
// Scoreboard bench for alu_op_executor: directed spec cases,
// flush/reset corners and random ops against a behavioural model.
module tb_alu_op_executor;

  logic clk;
  logic reset;
  logic flush;

  int n_cmp;
  int n_err;

  logic [32:0] sb[$];

  alu_op_executor_if #(.WIDTH(32)) bus ();

  alu_op_executor #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .bus   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [3:0] op,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
    logic [4:0]  sh;
    logic [31:0] r;
    logic        slt;
    sh  = b[4:0];
    slt = $signed(a) < $signed(b);
    case (op)
      4'd0:  r = a & b;
      4'd1:  r = a | b;
      4'd2:  r = a + b;
      4'd3:  r = a << sh;
      4'd4:  r = a >> sh;
      4'd5:  r = a - b;
      4'd6:  r = $signed(a) >>> sh;
      4'd7:  r = {31'd0, slt};
      4'd8:  r = {31'd0, a == b};
      4'd9:  r = {31'd0, a != b};
      4'd10: r = {31'd0, slt};
      4'd11: r = {31'd0, !slt};
      4'd12: r = a ^ b;
      4'd13: r = b;
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_op(input logic [3:0] op,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        input int hold);
    logic [31:0] r;
    logic [32:0] e;
    logic [4:0]  sh;
    int          exp_lat;
    int          lat;
    r  = model(op, a, b);
    sh = b[4:0];
    exp_lat = (op == 4'd3 || op == 4'd4 || op == 4'd6) ? 1 + int'(sh) : 1;
    sb.push_back({r == 32'd0, r});
    bus.in_op    = op;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_valid = 1'b1;
    chk("idle_ready", bus.in_ready, 1);
    tick();
    bus.in_valid = 1'b0;
    bus.in_a     = $urandom;
    bus.in_b     = $urandom;
    bus.in_op    = 4'($urandom);
    lat = 1;
    while (!bus.out_valid && lat < 100) begin
      chk("busy_ready", bus.in_ready, 0);
      tick();
      lat++;
    end
    chk("latency", lat, exp_lat);
    e = sb.pop_front();
    if (bus.out_valid) begin
      chk("result", bus.out_result, e[31:0]);
      chk("zero", bus.out_zero, e[32]);
      chk("done_ready", bus.in_ready, 0);
      for (int i = 0; i < hold; i++) begin
        tick();
        chk("hold_valid", bus.out_valid, 1);
        chk("hold_result", bus.out_result, e[31:0]);
      end
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      chk("release_valid", bus.out_valid, 0);
      chk("release_ready", bus.in_ready, 1);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    flush = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_op     = 4'd0;
    bus.in_a      = 32'd0;
    bus.in_b      = 32'd0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ready", bus.in_ready, 0);
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_result", bus.out_result, 0);
    chk("rst_zero", bus.out_zero, 0);
    reset = 1'b0;
    tick();
    chk("post_rst_ready", bus.in_ready, 1);

    run_op(4'b0010, 32'h7FFF_FFFF, 32'd1, 0);
    run_op(4'b0101, 32'd5, 32'd5, 0);
    run_op(4'b1000, 32'd9, 32'd9, 0);
    run_op(4'b0110, 32'h8000_0000, 32'd31, 0);
    run_op(4'b0011, 32'd1, 32'h20, 0);
    run_op(4'b0011, 32'd1, 32'd4, 0);
    run_op(4'b0111, 32'hFFFF_FFFF, 32'd1, 0);
    run_op(4'b1011, 32'hFFFF_FFFF, 32'd1, 0);
    run_op(4'b1110, 32'h1234_5678, 32'h9, 0);
    run_op(4'b1101, 32'h1, 32'hABCD_E000, 3);
    run_op(4'b0100, 32'hF000_0001, 32'hFFFF_FFE1, 2);
    run_op(4'b1001, 32'd3, 32'd3, 0);
    run_op(4'b1010, 32'h8000_0000, 32'd0, 0);
    run_op(4'b1100, 32'hFF00_FF00, 32'h0FF0_0FF0, 0);

    // SRL b=10 flushed in cycle 4
    bus.in_op    = 4'b0100;
    bus.in_a     = 32'hF000_0000;
    bus.in_b     = 32'd10;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    for (int c = 1; c < 4; c++) begin
      chk("flush_pre_valid", bus.out_valid, 0);
      tick();
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_ready", bus.in_ready, 1);
    chk("flush_valid", bus.out_valid, 0);
    repeat (12) tick();
    chk("flush_late_valid", bus.out_valid, 0);

    // flush with in_valid in IDLE accepts nothing
    bus.in_op    = 4'b0010;
    bus.in_a     = 32'd1;
    bus.in_b     = 32'd2;
    bus.in_valid = 1'b1;
    flush        = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    flush        = 1'b0;
    chk("flush_idle_valid", bus.out_valid, 0);
    chk("flush_idle_ready", bus.in_ready, 1);

    // flush together with out_ready in DONE
    bus.in_op    = 4'b0010;
    bus.in_a     = 32'd2;
    bus.in_b     = 32'd3;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    chk("fd_valid", bus.out_valid, 1);
    chk("fd_result", bus.out_result, 32'd5);
    flush         = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    flush         = 1'b0;
    bus.out_ready = 1'b0;
    chk("fd_after_valid", bus.out_valid, 0);
    chk("fd_after_ready", bus.in_ready, 1);

    // reset mid-shift drops the op and clears the result
    bus.in_op    = 4'b0011;
    bus.in_a     = 32'd1;
    bus.in_b     = 32'd20;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    tick();
    chk("mid_rst_ready", bus.in_ready, 0);
    chk("mid_rst_valid", bus.out_valid, 0);
    chk("mid_rst_result", bus.out_result, 0);
    chk("mid_rst_zero", bus.out_zero, 0);
    reset = 1'b0;
    tick();
    chk("mid_rst_ready2", bus.in_ready, 1);
    repeat (25) tick();
    chk("mid_rst_late_valid", bus.out_valid, 0);

    for (int i = 0; i < 30; i++) begin
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      op = 4'($urandom_range(0, 15));
      a  = $urandom;
      b  = $urandom;
      if ($urandom_range(0, 3) == 0) b = a;
      run_op(op, a, b, $urandom_range(0, 2));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
